// File: rtl/rename_regfile_pkg.sv
// Shared types and constants for the rename register file: widths, tag/data
// types and the commit-bundle struct passed to the read ports.
package rename_regfile_pkg;

    localparam int REG_NUM   = 32;
    localparam int REG_POS_W = 5;
    localparam int DATA_W    = 32;
    localparam int ROB_ID_W  = 5;

    typedef logic [REG_POS_W-1:0] reg_pos_t;
    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [ROB_ID_W-1:0]  rob_id_t;

    localparam reg_pos_t ZERO_REG  = '0;
    localparam data_t    ZERO_WORD = '0;
    localparam rob_id_t  ZERO_ROB  = '0;

    // One ROB commit beat as seen by the storage and the read bypass.
    typedef struct packed {
        logic     valid;
        reg_pos_t rd;
        rob_id_t  q;
        data_t    v;
    } commit_t;

    // x0 is never written, so every write enable is qualified here.
    function automatic logic writes_reg(input logic en, input reg_pos_t rd);
        return en && (rd != ZERO_REG);
    endfunction

endpackage

// File: rtl/rename_regfile_read_port.sv
// One dispatcher operand read: hardwired x0, then same-cycle commit bypass,
// then the stored tag/value.
module rename_regfile_read_port
    import rename_regfile_pkg::*;
(
    input  reg_pos_t rs_i,
    input  rob_id_t  q_entry_i,
    input  data_t    v_entry_i,
    input  commit_t  commit_i,
    output rob_id_t  q_o,
    output data_t    v_o
);

    logic bypass_hit;

    // Only the producer the register still waits on may bypass; a stale tag
    // commit must not hide a newer rename.
    assign bypass_hit = commit_i.valid && (commit_i.rd == rs_i) && (commit_i.q == q_entry_i);

    always_comb begin
        q_o = q_entry_i;
        v_o = v_entry_i;
        if (rs_i == ZERO_REG) begin
            q_o = ZERO_ROB;
            v_o = ZERO_WORD;
        end else if (bypass_hit) begin
            q_o = ZERO_ROB;
            v_o = commit_i.v;
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register ROB rename tags: takes the
// ROB commit stream and dispatcher renames, and serves two operand reads.
module rename_regfile
    import rename_regfile_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  reg_pos_t rs1_from_dsp,
    input  reg_pos_t rs2_from_dsp,
    output rob_id_t  Q1_to_dsp,
    output rob_id_t  Q2_to_dsp,
    output data_t    V1_to_dsp,
    output data_t    V2_to_dsp,
    input  logic     ena_from_dsp,
    input  reg_pos_t rd_from_dsp,
    input  rob_id_t  Q_from_dsp,
    input  logic     commit_flag,
    input  reg_pos_t rd_from_rob,
    input  rob_id_t  Q_from_rob,
    input  data_t    V_from_rob,
    input  logic     commit_jump_flag
);

    logic [REG_NUM-1:0][ROB_ID_W-1:0] q_q, q_d;
    logic [REG_NUM-1:0][DATA_W-1:0]   v_q, v_d;

    commit_t commit;
    logic    commit_we;
    logic    rename_we;

    assign commit.valid = commit_flag;
    assign commit.rd    = rd_from_rob;
    assign commit.q     = Q_from_rob;
    assign commit.v     = V_from_rob;

    // rdy is a global stall, not a handshake: while it is low no input is
    // consumed and state holds, but reads (including the bypass) stay live.
    assign commit_we = rdy && writes_reg(commit_flag, rd_from_rob);
    assign rename_we = rdy && !commit_jump_flag && writes_reg(ena_from_dsp, rd_from_dsp);

    always_comb begin
        q_d = q_q;
        v_d = v_q;
        if (commit_we) begin
            v_d[rd_from_rob] = V_from_rob;
            if (q_q[rd_from_rob] == Q_from_rob) begin
                q_d[rd_from_rob] = ZERO_ROB;
            end
        end
        if (rdy && commit_jump_flag) begin
            q_d = '0;
        end
        // Applied after the commit clear so a same-rd rename keeps the new tag.
        if (rename_we) begin
            q_d[rd_from_dsp] = Q_from_dsp;
        end
        q_d[ZERO_REG] = ZERO_ROB;
        v_d[ZERO_REG] = ZERO_WORD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
            v_q <= '0;
        end else begin
            q_q <= q_d;
            v_q <= v_d;
        end
    end

    rename_regfile_read_port u_rd1 (
        .rs_i      (rs1_from_dsp),
        .q_entry_i (q_q[rs1_from_dsp]),
        .v_entry_i (v_q[rs1_from_dsp]),
        .commit_i  (commit),
        .q_o       (Q1_to_dsp),
        .v_o       (V1_to_dsp)
    );

    rename_regfile_read_port u_rd2 (
        .rs_i      (rs2_from_dsp),
        .q_entry_i (q_q[rs2_from_dsp]),
        .v_entry_i (v_q[rs2_from_dsp]),
        .commit_i  (commit),
        .q_o       (Q2_to_dsp),
        .v_o       (V2_to_dsp)
    );

endmodule

// File: tb/tb_rename_regfile.sv
// Bench for rename_regfile: directed vector table, reset corner sequences and
// a randomized run against an array-based reference model.
module tb_rename_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic [4:0]  rs1_from_dsp = '0, rs2_from_dsp = '0;
    logic [4:0]  Q1_to_dsp, Q2_to_dsp;
    logic [31:0] V1_to_dsp, V2_to_dsp;
    logic        ena_from_dsp = 1'b0;
    logic [4:0]  rd_from_dsp = '0, Q_from_dsp = '0;
    logic        commit_flag = 1'b0;
    logic [4:0]  rd_from_rob = '0, Q_from_rob = '0;
    logic [31:0] V_from_rob = '0;
    logic        commit_jump_flag = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [36:0] exp_q[$];

    logic [4:0]  ref_q[32];
    logic [31:0] ref_v[32];

    typedef struct {
        logic        rdy;
        logic [4:0]  rs1, rs2;
        logic        ena;
        logic [4:0]  rdd, qd;
        logic        cf;
        logic [4:0]  rdr, qr;
        logic [31:0] vr;
        logic        jf;
        logic [4:0]  eq1;
        logic [31:0] ev1;
        logic [4:0]  eq2;
        logic [31:0] ev2;
    } vec_t;

    vec_t vecs[18];

    rename_regfile dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .rs1_from_dsp     (rs1_from_dsp),
        .rs2_from_dsp     (rs2_from_dsp),
        .Q1_to_dsp        (Q1_to_dsp),
        .Q2_to_dsp        (Q2_to_dsp),
        .V1_to_dsp        (V1_to_dsp),
        .V2_to_dsp        (V2_to_dsp),
        .ena_from_dsp     (ena_from_dsp),
        .rd_from_dsp      (rd_from_dsp),
        .Q_from_dsp       (Q_from_dsp),
        .commit_flag      (commit_flag),
        .rd_from_rob      (rd_from_rob),
        .Q_from_rob       (Q_from_rob),
        .V_from_rob       (V_from_rob),
        .commit_jump_flag (commit_jump_flag)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && rdy && ena_from_dsp) begin
            assert (Q_from_dsp != 5'd0) else $error("illegal rename with tag 0");
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                         input logic en, input logic [4:0] rdd, input logic [4:0] qd,
                         input logic cf, input logic [4:0] rdr, input logic [4:0] qr,
                         input logic [31:0] vr, input logic jf);
        rdy = r; rs1_from_dsp = s1; rs2_from_dsp = s2;
        ena_from_dsp = en; rd_from_dsp = rdd; Q_from_dsp = qd;
        commit_flag = cf; rd_from_rob = rdr; Q_from_rob = qr; V_from_rob = vr;
        commit_jump_flag = jf;
    endtask

    task automatic drive_idle(input logic [4:0] s1, input logic [4:0] s2);
        drive(1'b1, s1, s2, 1'b0, 5'd0, 5'd1, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
    endtask

    function automatic vec_t mk(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                                input logic en, input logic [4:0] rdd, input logic [4:0] qd,
                                input logic cf, input logic [4:0] rdr, input logic [4:0] qr,
                                input logic [31:0] vr, input logic jf,
                                input logic [4:0] eq1, input logic [31:0] ev1,
                                input logic [4:0] eq2, input logic [31:0] ev2);
        vec_t v;
        v.rdy = r; v.rs1 = s1; v.rs2 = s2; v.ena = en; v.rdd = rdd; v.qd = qd;
        v.cf = cf; v.rdr = rdr; v.qr = qr; v.vr = vr; v.jf = jf;
        v.eq1 = eq1; v.ev1 = ev1; v.eq2 = eq2; v.ev2 = ev2;
        return v;
    endfunction

    task automatic check_port(input string name, input logic [4:0] aq, input logic [31:0] av,
                              input logic [4:0] eq, input logic [31:0] ev);
        n_vec++;
        if (aq !== eq || av !== ev) begin
            n_err++;
            $display("FAIL %s: got Q=%0d V=%h, expected Q=%0d V=%h", name, aq, av, eq, ev);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [36:0] model_read(input logic [4:0] rs);
        if (rs == 5'd0) return 37'd0;
        if (commit_flag && rd_from_rob == rs && Q_from_rob == ref_q[rs])
            return {5'd0, V_from_rob};
        return {ref_q[rs], ref_v[rs]};
    endfunction

    task automatic model_edge();
        logic [4:0] tag_before;
        if (!rdy) return;
        if (commit_flag && rd_from_rob != 5'd0) begin
            tag_before = ref_q[rd_from_rob];
            ref_v[rd_from_rob] = V_from_rob;
            if (tag_before == Q_from_rob) ref_q[rd_from_rob] = 5'd0;
        end
        if (commit_jump_flag) begin
            for (int i = 0; i < 32; i++) ref_q[i] = 5'd0;
        end else if (ena_from_dsp && rd_from_dsp != 5'd0) begin
            ref_q[rd_from_dsp] = Q_from_dsp;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            ref_q[i] = 5'd0;
            ref_v[i] = 32'd0;
        end
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        logic [36:0] e;
        //               rdy rs1   rs2   ena rdd   qd    cf rdr   qr    vr            jf | eq1  ev1           eq2  ev2
        vecs[0]  = mk(1, 5'd5, 5'd0, 1, 5'd5, 5'd3, 0, 5'd0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd0, 32'h0);
        vecs[1]  = mk(1, 5'd5, 5'd6, 0, 5'd0, 5'd1, 0, 5'd0, 5'd0, 32'h0,        0, 5'd3, 32'h0,        5'd0, 32'h0);
        vecs[2]  = mk(1, 5'd5, 5'd5, 0, 5'd0, 5'd1, 1, 5'd5, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'hDEADBEEF, 5'd0, 32'hDEADBEEF);
        vecs[3]  = mk(1, 5'd5, 5'd7, 1, 5'd5, 5'd3, 0, 5'd0, 5'd0, 32'h0,        0, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0);
        vecs[4]  = mk(1, 5'd5, 5'd0, 1, 5'd5, 5'd7, 0, 5'd0, 5'd0, 32'h0,        0, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0);
        vecs[5]  = mk(1, 5'd5, 5'd6, 1, 5'd6, 5'd4, 1, 5'd5, 5'd3, 32'h11,       0, 5'd7, 32'hDEADBEEF, 5'd0, 32'h0);
        vecs[6]  = mk(1, 5'd5, 5'd6, 1, 5'd6, 5'd9, 1, 5'd6, 5'd4, 32'h22,       0, 5'd7, 32'h11,       5'd0, 32'h22);
        vecs[7]  = mk(1, 5'd6, 5'd0, 1, 5'd0, 5'd2, 1, 5'd0, 5'd2, 32'h5,        0, 5'd9, 32'h22,       5'd0, 32'h0);
        vecs[8]  = mk(1, 5'd0, 5'd6, 1, 5'd1, 5'd1, 0, 5'd0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd9, 32'h22);
        vecs[9]  = mk(1, 5'd1, 5'd0, 1, 5'd2, 5'd2, 0, 5'd0, 5'd0, 32'h0,        0, 5'd1, 32'h0,        5'd0, 32'h0);
        vecs[10] = mk(1, 5'd2, 5'd1, 1, 5'd3, 5'd3, 0, 5'd0, 5'd0, 32'h0,        0, 5'd2, 32'h0,        5'd1, 32'h0);
        vecs[11] = mk(1, 5'd3, 5'd2, 1, 5'd4, 5'd4, 0, 5'd0, 5'd0, 32'h0,        0, 5'd3, 32'h0,        5'd2, 32'h0);
        vecs[12] = mk(0, 5'd1, 5'd4, 1, 5'd2, 5'd6, 1, 5'd1, 5'd1, 32'h80,       1, 5'd0, 32'h80,       5'd4, 32'h0);
        vecs[13] = mk(1, 5'd1, 5'd2, 1, 5'd2, 5'd6, 1, 5'd1, 5'd1, 32'h80,       1, 5'd0, 32'h80,       5'd2, 32'h0);
        vecs[14] = mk(1, 5'd1, 5'd2, 0, 5'd0, 5'd1, 0, 5'd0, 5'd0, 32'h0,        0, 5'd0, 32'h80,       5'd0, 32'h0);
        vecs[15] = mk(1, 5'd5, 5'd6, 0, 5'd0, 5'd1, 0, 5'd0, 5'd0, 32'h0,        0, 5'd0, 32'h11,       5'd0, 32'h22);
        vecs[16] = mk(1, 5'd4, 5'd3, 0, 5'd0, 5'd1, 0, 5'd0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd0, 32'h0);
        vecs[17] = mk(1, 5'd0, 5'd0, 0, 5'd0, 5'd1, 0, 5'd0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        5'd0, 32'h0);

        // Reset pulse, checked both while held and after release.
        drive_idle(5'd5, 5'd0);
        #2;
        check_port("reset_held_rs1", Q1_to_dsp, V1_to_dsp, 5'd0, 32'h0);
        do_reset();
        drive_idle(5'd5, 5'd0);
        #2;
        check_port("post_reset_x5", Q1_to_dsp, V1_to_dsp, 5'd0, 32'h0);

        // Directed table: rename, bypass, stale commit, same-rd race, x0, flush, stall.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i].rdy, vecs[i].rs1, vecs[i].rs2, vecs[i].ena, vecs[i].rdd, vecs[i].qd,
                  vecs[i].cf, vecs[i].rdr, vecs[i].qr, vecs[i].vr, vecs[i].jf);
            #2;
            check_port($sformatf("vec%0d_rs1", i), Q1_to_dsp, V1_to_dsp, vecs[i].eq1, vecs[i].ev1);
            check_port($sformatf("vec%0d_rs2", i), Q2_to_dsp, V2_to_dsp, vecs[i].eq2, vecs[i].ev2);
        end

        // Mid-cycle async reset with a commit and rename pending across an edge.
        @(negedge clk);
        drive(1'b1, 5'd5, 5'd6, 1'b1, 5'd8, 5'd3, 1'b1, 5'd7, 5'd1, 32'hAA, 1'b0);
        #1 rst = 1'b0;
        #1;
        check_port("async_reset_x5", Q1_to_dsp, V1_to_dsp, 5'd0, 32'h0);
        check_port("async_reset_x6", Q2_to_dsp, V2_to_dsp, 5'd0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive_idle(5'd7, 5'd8);
        #2;
        check_port("reset_drops_commit", Q1_to_dsp, V1_to_dsp, 5'd0, 32'h0);
        check_port("reset_drops_rename", Q2_to_dsp, V2_to_dsp, 5'd0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        drive_idle(5'd1, 5'd5);
        #2;
        check_port("after_reset_x1", Q1_to_dsp, V1_to_dsp, 5'd0, 32'h0);
        check_port("after_reset_x5", Q2_to_dsp, V2_to_dsp, 5'd0, 32'h0);

        // Randomized run against the reference model.
        model_clear();
        for (int c = 0; c < 1500; c++) begin
            logic [4:0] rdr_r;
            @(negedge clk);
            rdr_r = 5'($urandom_range(0, 7));
            drive(($urandom_range(0, 9) != 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(1, 31)),
                  1'($urandom_range(0, 1)), rdr_r,
                  ($urandom_range(0, 2) != 0) ? ref_q[rdr_r] : 5'($urandom_range(0, 31)),
                  $urandom, ($urandom_range(0, 19) == 0));
            #2;
            exp_q.push_back(model_read(rs1_from_dsp));
            exp_q.push_back(model_read(rs2_from_dsp));
            e = exp_q.pop_front();
            check_port($sformatf("rand%0d_rs1", c), Q1_to_dsp, V1_to_dsp, e[36:32], e[31:0]);
            e = exp_q.pop_front();
            check_port($sformatf("rand%0d_rs2", c), Q2_to_dsp, V2_to_dsp, e[36:32], e[31:0]);
            @(posedge clk);
            model_edge();
        end

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
